// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the execute stage and the multiply/divide unit.
// The pipeline side drives the request; the unit side returns HI/LO and status.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divByZero;

  modport master (
    output start, operation, a, b,
    input  hi, lo, busy, done, divByZero
  );

  modport slave (
    input  start, operation, a, b,
    output hi, lo, busy, done, divByZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Multiplies by shift-add and divides by restoring division, one bit per cycle,
// on operand magnitudes; signs are reapplied in the FINISH cycle.
// A single 2*WIDTH accumulator is shared: {upper, lower} holds the partial
// product/multiplier for multiplies and {remainder, dividend/quotient} for divides.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  mult_div_unit_if.slave    md_if
);

  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // Magnitude of an operand; for signed ops the most negative value maps to
  // itself, which is the correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic             sgn);
    logic [WIDTH-1:0] r;
    if (sgn && v[WIDTH-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               op_signed;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;

  assign op_signed = (md_if.operation == OP_MULT) || (md_if.operation == OP_DIV);

  // Per-iteration datapath and final sign correction, computed from registered state.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_ge) begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    prod_fin = neg_res_q ? -acc_q : acc_q;
    quo_fin  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fin  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register-update logic for the IDLE/RUN/FINISH sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (md_if.start) begin
          case (md_if.operation)
            OP_MULT, OP_MULTU: begin
              opnd_d    = abs_val(md_if.a, op_signed);
              acc_d     = {{WIDTH{1'b0}}, abs_val(md_if.b, op_signed)};
              is_div_d  = 1'b0;
              neg_res_d = op_signed & (md_if.a[WIDTH-1] ^ md_if.b[WIDTH-1]);
              neg_rem_d = 1'b0;
              cnt_d     = {CNT_W{1'b0}};
              busy_d    = 1'b1;
              state_d   = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              if (md_if.b == {WIDTH{1'b0}}) begin
                // No iteration: flag immediately, leave HI/LO untouched.
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                opnd_d    = abs_val(md_if.b, op_signed);
                acc_d     = {{WIDTH{1'b0}}, abs_val(md_if.a, op_signed)};
                is_div_d  = 1'b1;
                neg_res_d = op_signed & (md_if.a[WIDTH-1] ^ md_if.b[WIDTH-1]);
                neg_rem_d = op_signed & md_if.a[WIDTH-1];
                cnt_d     = {CNT_W{1'b0}};
                busy_d    = 1'b1;
                state_d   = ST_RUN;
              end
            end
            OP_MTHI: hi_d = md_if.a;
            OP_MTLO: lo_d = md_if.a;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FINISH: begin
        if (is_div_q) begin
          lo_d = quo_fin;
          hi_d = rem_fin;
        end else begin
          hi_d = prod_fin[2*WIDTH-1:WIDTH];
          lo_d = prod_fin[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset discarding any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign md_if.hi        = hi_q;
  assign md_if.lo        = lo_q;
  assign md_if.busy      = busy_q;
  assign md_if.done      = done_q;
  assign md_if.divByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   edges;
  int   busy_cnt;
  int   pulses;

  mult_div_unit_if #(.WIDTH(32)) mdu_if ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (mdu_if)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after an edge; presents a request for exactly one edge.
  task automatic do_start(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    mdu_if.start     = 1'b1;
    mdu_if.operation = op;
    mdu_if.a         = av;
    mdu_if.b         = bv;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
  endtask

  // Counts edges until done (bounded) and samples where busy was high.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = mdu_if.busy ? 1 : 0;
    while (!mdu_if.done && n_edges < 100) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (mdu_if.busy) n_busy++;
    end
    if (!mdu_if.done) check_val("done_timeout", {63'd0, mdu_if.done}, 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mdu_if.start     = 1'b0;
    mdu_if.operation = 6'b000000;
    mdu_if.a         = 32'h0000_0000;
    mdu_if.b         = 32'h0000_0000;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hi",   {32'd0, mdu_if.hi}, 64'd0);
    check_val("rst_lo",   {32'd0, mdu_if.lo}, 64'd0);
    check_val("rst_busy", {63'd0, mdu_if.busy}, 64'd0);
    check_val("rst_done", {63'd0, mdu_if.done}, 64'd0);
    check_val("rst_dbz",  {63'd0, mdu_if.divByZero}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // MULT -3 * 5 = -15
    do_start(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    check_val("mult_busy_e0", {63'd0, mdu_if.busy}, 64'd1);
    wait_done(edges, busy_cnt);
    check_val("mult_latency", 64'(edges), 64'd33);
    check_val("mult_busy_cycles", 64'(busy_cnt), 64'd33);
    check_val("mult_hi", {32'd0, mdu_if.hi}, 64'h0000_0000_FFFF_FFFF);
    check_val("mult_lo", {32'd0, mdu_if.lo}, 64'h0000_0000_FFFF_FFF1);
    check_val("mult_dbz", {63'd0, mdu_if.divByZero}, 64'd0);
    @(posedge clk);
    #1;
    check_val("mult_done_1cyc", {63'd0, mdu_if.done}, 64'd0);

    // MULTU 0xFFFFFFFF^2, then DIVU issued in the done cycle
    do_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(edges, busy_cnt);
    check_val("multu_hi", {32'd0, mdu_if.hi}, 64'h0000_0000_FFFF_FFFE);
    check_val("multu_lo", {32'd0, mdu_if.lo}, 64'h0000_0000_0000_0001);
    do_start(OP_DIVU, 32'd100, 32'd7);
    check_val("b2b_busy", {63'd0, mdu_if.busy}, 64'd1);
    wait_done(edges, busy_cnt);
    check_val("divu_latency", 64'(edges), 64'd33);
    check_val("divu_lo", {32'd0, mdu_if.lo}, 64'd14);
    check_val("divu_hi", {32'd0, mdu_if.hi}, 64'd2);

    // DIV -7 / 2 = -3 rem -1
    do_start(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(edges, busy_cnt);
    check_val("div_neg_lo", {32'd0, mdu_if.lo}, 64'h0000_0000_FFFF_FFFD);
    check_val("div_neg_hi", {32'd0, mdu_if.hi}, 64'h0000_0000_FFFF_FFFF);

    // Overflow case: most negative / -1
    do_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(edges, busy_cnt);
    check_val("div_ovf_lo", {32'd0, mdu_if.lo}, 64'h0000_0000_8000_0000);
    check_val("div_ovf_hi", {32'd0, mdu_if.hi}, 64'd0);
    check_val("div_ovf_dbz", {63'd0, mdu_if.divByZero}, 64'd0);

    // Divide by zero with known HI/LO
    do_start(OP_MTHI, 32'h0000_0011, 32'h0000_0000);
    do_start(OP_MTLO, 32'h0000_0022, 32'h0000_0000);
    do_start(OP_DIV, 32'h0000_0005, 32'h0000_0000);
    check_val("dbz_done", {63'd0, mdu_if.done}, 64'd1);
    check_val("dbz_flag", {63'd0, mdu_if.divByZero}, 64'd1);
    check_val("dbz_busy", {63'd0, mdu_if.busy}, 64'd0);
    check_val("dbz_hi", {32'd0, mdu_if.hi}, 64'h11);
    check_val("dbz_lo", {32'd0, mdu_if.lo}, 64'h22);
    @(posedge clk);
    #1;
    check_val("dbz_done_clr", {63'd0, mdu_if.done}, 64'd0);
    check_val("dbz_flag_clr", {63'd0, mdu_if.divByZero}, 64'd0);
    check_val("dbz_busy_after", {63'd0, mdu_if.busy}, 64'd0);

    // MTHI / MTLO
    do_start(OP_MTHI, 32'hDEAD_BEEF, 32'h0000_0000);
    check_val("mthi_hi", {32'd0, mdu_if.hi}, 64'h0000_0000_DEAD_BEEF);
    check_val("mthi_done", {63'd0, mdu_if.done}, 64'd0);
    check_val("mthi_busy", {63'd0, mdu_if.busy}, 64'd0);
    do_start(OP_MTLO, 32'h1234_5678, 32'h0000_0000);
    check_val("mtlo_lo", {32'd0, mdu_if.lo}, 64'h0000_0000_1234_5678);
    check_val("mtlo_hi_keep", {32'd0, mdu_if.hi}, 64'h0000_0000_DEAD_BEEF);

    // Start while busy is ignored; operand changes during RUN have no effect
    do_start(OP_MULT, 32'd3, 32'd4);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    do_start(OP_MTHI, 32'h0000_CAFE, 32'h0000_0009);
    check_val("busy_mthi_ign", {32'd0, mdu_if.hi}, 64'h0000_0000_DEAD_BEEF);
    wait_done(edges, busy_cnt);
    check_val("busy_mult_lo", {32'd0, mdu_if.lo}, 64'd12);
    check_val("busy_mult_hi", {32'd0, mdu_if.hi}, 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a MULT
    do_start(OP_MULT, 32'd7, 32'd9);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("midrst_hi", {32'd0, mdu_if.hi}, 64'd0);
    check_val("midrst_lo", {32'd0, mdu_if.lo}, 64'd0);
    check_val("midrst_busy", {63'd0, mdu_if.busy}, 64'd0);
    check_val("midrst_done", {63'd0, mdu_if.done}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mdu_if.done) pulses++;
    end
    check_val("midrst_no_done", 64'(pulses), 64'd0);
    do_start(OP_MULT, 32'd7, 32'd9);
    wait_done(edges, busy_cnt);
    check_val("post_rst_latency", 64'(edges), 64'd33);
    check_val("post_rst_lo", {32'd0, mdu_if.lo}, 64'd63);
    check_val("post_rst_hi", {32'd0, mdu_if.hi}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit in the execute stage, operating alongside the ALU on the same a/b operands and function code. It owns the HI/LO register pair, computes MULT/MULTU/DIV/DIVU over multiple cycles (one bit per cycle), and supports the single-cycle MTHI/MTLO writes. Writeback reads HI/LO directly for MFHI/MFLO. The pipeline stalls on busy.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only when busy=0
operation  input  6  function code: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO
a  input  WIDTH  operand rs (multiplicand / dividend / MTHI-MTLO source)
b  input  WIDTH  operand rt (multiplier / divisor)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  iteration in progress; pipeline must stall
done  output  1  one-cycle pulse; hi/lo hold the new result in the same cycle
divByZero  output  1  one-cycle pulse with done when a divide had b==0

Behaviour:
- Reset (sync, active-high, on any edge where reset=1, including mid-operation): state IDLE; hi=0, lo=0, busy=0, done=0, divByZero=0; iteration counter and working registers cleared; an in-flight result is discarded.
- States: IDLE, RUN, FINISH.
- IDLE: start=1 at edge E0 with
  - MULT/MULTU/DIV/DIVU (b!=0): latch operand magnitudes (signed ops: absolute value of two's complement, -2^31 stays 0x80000000 unsigned) and result signs. Go to RUN with counter=0 and busy=1 after E0.
  - DIV/DIVU with b==0: no iteration; after E0 done=1, divByZero=1, busy stays 0, hi/lo unchanged, remain IDLE.
  - MTHI: hi<=a at E0. MTLO: lo<=a at E0. No busy, no done.
  - Any other code: ignored, no state change.
- RUN: one iteration per edge, counter increments.
  - Multiply: shift-add on a 2*WIDTH unsigned product.
  - Divide: restoring division, one quotient bit per edge.
  - After WIDTH iterations (edge E_WIDTH), go to FINISH. busy stays 1 through E_WIDTH.
- FINISH transition (edge E_WIDTH+1):
  - Apply sign correction.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write hi/lo: product upper/lower; quotient->lo, remainder->hi.
  - After that edge: done=1 for exactly one cycle, busy=0, state IDLE.
  - Start-to-done latency: WIDTH+1 edges (33 at default).
- done pulses the same cycle hi/lo first show the new value. A start sampled in that done cycle is accepted (back-to-back).
- start while busy=1: ignored entirely; operands and operation are not re-latched.
- Operands are latched at E0. a/b/operation may change during RUN with no effect.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- No overflow exceptions; MULTU/DIVU ignore signs.
- hi/lo change only on FINISH, MTHI/MTLO, or reset.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> busy high 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU a=100, b=7 issued in the done cycle -> accepted; lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> done and divByZero pulse one cycle after start; busy never rises; hi/lo remain 0x11/0x22.
- MTHI a=0xDEADBEEF, then MTLO a=0x12345678 -> hi/lo update the edge after each start; no done. During a MULT, a second start with MTHI is ignored (hi unchanged until the MULT result lands).
- Start MULT 7*9, assert reset at iteration 10 -> the following cycle hi=lo=0, busy=0, done=0; no done pulse afterwards. A new MULT 7*9 then gives lo=63, hi=0.
